i_fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the 256-word asynchronous instruction ROM and buffers fetched words in a small FIFO toward decode. It owns the program counter and drives the ROM address every cycle. It delivers {instruction, PC} pairs over a valid/ready handshake, and flushes and refetches on a branch/jump redirect from execute. It sits between `i_rom` and the decode stage of the single-clock CPU.

---
 rtl/i_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_i_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through an asynchronous ROM and
// queues {inst, pc} pairs in a small FIFO toward decode, with redirect flush.
module i_fetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {FETCH, FAULT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_pc_q   [DEPTH];
  logic            push, pop;

  assign rom_addr   = pc_q[ADDR_W+1:2];
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? mem_inst_q[head_q] : NOP;
  assign inst_pc    = inst_valid ? mem_pc_q[head_q] : 32'h0;
  assign count      = count_q;
  assign fault      = (state_q == FAULT);

  assign pop  = inst_valid && inst_ready;
  assign push = (state_q == FETCH) && !redirect_valid && ((count_q < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        mem_inst_q[tail_q] <= rom_data;
        mem_pc_q[tail_q]   <= pc_q;
      end
    end
  end

  // Redirect wins over push/pop; a misaligned target parks the block in FAULT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        state_d = FETCH;
        pc_d    = redirect_pc;
      end else begin
        state_d = FAULT;
      end
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// Directed bench for i_fetch_ctrl: behavioural async ROM plus per-scenario
// tasks that compare outputs against hand-computed values.
module tb_i_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  count;
  logic        fault;

  logic [31:0] memory [256];
  int checks = 0;
  int errors = 0;

  i_fetch_ctrl #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .count(count), .fault(fault)
  );

  always #5 clk = ~clk;
  assign rom_data = memory[rom_addr];

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || count !== 3'd0 || fault !== 1'b0 || rom_addr !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got v=%b inst=%h pc=%h cnt=%0d f=%b ra=%0d expected v=0 inst=%h pc=0 cnt=0 f=0 ra=0",
               inst_valid, inst, inst_pc, count, fault, rom_addr, NOP);
    end
  endtask

  task automatic test_stream();
    inst_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst !== memory[k]) begin
        errors++;
        $display("[TB] FAIL stream[%0d] got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, 32'(4 * k), memory[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    tick(10);
    checks++;
    if (count !== 3'd4 || rom_addr !== 8'd4 || inst_pc !== 32'h0 || inst !== memory[0]) begin
      errors++;
      $display("[TB] FAIL bp_full got cnt=%0d ra=%0d pc=%h inst=%h expected cnt=4 ra=4 pc=0 inst=%h",
               count, rom_addr, inst_pc, inst, memory[0]);
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || count !== 3'd4) begin
        errors++;
        $display("[TB] FAIL bp_drain[%0d] got v=%b pc=%h cnt=%0d expected v=1 pc=%h cnt=4",
                 k, inst_valid, inst_pc, count, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    inst_ready = 1'b0;
    tick(3);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("[TB] FAIL flush_pre got cnt=%0d expected 3", count);
    end
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || rom_addr !== 8'd16) begin
      errors++;
      $display("[TB] FAIL flush_empty got cnt=%0d v=%b inst=%h pc=%h ra=%0d expected cnt=0 v=0 inst=%h pc=0 ra=16",
               count, inst_valid, inst, inst_pc, rom_addr, NOP);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== memory[16] || count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL flush_target got v=%b pc=%h inst=%h cnt=%0d expected v=1 pc=40 inst=%h cnt=1",
               inst_valid, inst_pc, inst, count, memory[16]);
    end
    tick();
    checks++;
    if (inst_pc !== 32'h44 || inst !== memory[17]) begin
      errors++;
      $display("[TB] FAIL flush_next got pc=%h inst=%h expected pc=44 inst=%h", inst_pc, inst, memory[17]);
    end
  endtask

  task automatic test_fault();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (fault !== 1'b1 || count !== 3'd0 || inst_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fault_hold[%0d] got f=%b cnt=%0d v=%b expected f=1 cnt=0 v=0", k, fault, count, inst_valid);
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h81;
    tick();
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_misaligned_again got f=%b expected 1", fault);
    end
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 8'd32) begin
      errors++;
      $display("[TB] FAIL fault_exit got f=%b v=%b ra=%0d expected f=0 v=0 ra=32", fault, inst_valid, rom_addr);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst !== memory[32]) begin
      errors++;
      $display("[TB] FAIL fault_refetch got v=%b pc=%h inst=%h expected v=1 pc=80 inst=%h",
               inst_valid, inst_pc, inst, memory[32]);
    end
  endtask

  task automatic test_wrap();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (rom_addr !== 8'd255) begin
      errors++;
      $display("[TB] FAIL wrap_addr255 got ra=%0d expected 255", rom_addr);
    end
    tick();
    checks++;
    if (inst_pc !== 32'h3FC || inst !== memory[255] || rom_addr !== 8'd0) begin
      errors++;
      $display("[TB] FAIL wrap_first got pc=%h inst=%h ra=%0d expected pc=3fc inst=%h ra=0",
               inst_pc, inst, rom_addr, memory[255]);
    end
    tick();
    checks++;
    if (inst_pc !== 32'h400 || inst !== memory[0]) begin
      errors++;
      $display("[TB] FAIL wrap_second got pc=%h inst=%h expected pc=400 inst=%h", inst_pc, inst, memory[0]);
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick(6);
    checks++;
    if (count !== 3'd4 || rom_addr !== 8'd68) begin
      errors++;
      $display("[TB] FAIL midrst_full got cnt=%0d ra=%0d expected cnt=4 ra=68", count, rom_addr);
    end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || fault !== 1'b0 || rom_addr !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midrst_full_reset got cnt=%0d v=%b inst=%h pc=%h f=%b ra=%0d expected all reset values",
               count, inst_valid, inst, inst_pc, fault, rom_addr);
    end
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_fault_entry got f=%b expected 1", fault);
    end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || count !== 3'd0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || rom_addr !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midrst_fault_reset got f=%b cnt=%0d v=%b inst=%h pc=%h ra=%0d expected reset values",
               fault, count, inst_valid, inst, inst_pc, rom_addr);
    end
    rst = 1'b0;
    inst_ready = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== memory[0]) begin
      errors++;
      $display("[TB] FAIL midrst_restart got v=%b pc=%h inst=%h expected v=1 pc=0 inst=%h",
               inst_valid, inst_pc, inst, memory[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memory[i] = 32'hA500_0000 + 32'(i * 3 + 1);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
